// File: rtl/packetizer_pkg.sv
// Shared definitions for the AXI-Stream packetizer: FSM encoding, keep constant
// and the packet-length latch rule.
package packetizer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam int unsigned KEEP_MAX_W = 64;
  localparam logic [KEEP_MAX_W-1:0] KEEP_ALL = '1;

  // A zero length request is treated as single-beat packets.
  function automatic logic [31:0] eff_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push while full succeeds only
// when a pop happens in the same cycle. Flush empties it in one cycle.
module sync_fifo
  import packetizer_pkg::*;
#(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axis_packetizer.sv
// Turns a backpressure-free sample strobe into fixed-length AXI-Stream packets,
// padding an interrupted packet with zero beats so tlast is always delivered.
module axis_packetizer
  import packetizer_pkg::*;
#(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic            sys_clk_i,
  input  logic            sys_rstn_i,
  input  logic            enable_i,
  input  logic [31:0]     pkt_len_i,
  input  logic            smp_valid_i,
  input  logic [DW-1:0]   smp_data_i,
  output logic [DW-1:0]   m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic [DW/8-1:0] m_axis_tkeep,
  output logic [31:0]     drop_cnt_o,
  output logic [31:0]     pkt_cnt_o,
  output logic            busy_o
);

  logic [1:0]    rst_sync;
  logic          rst_n;

  state_t        state_q, state_d;
  logic [31:0]   beat_q, beat_d;
  logic [31:0]   len_q, len_d;
  logic [31:0]   drop_q;
  logic [31:0]   pkt_q;

  logic          push, pop, flush;
  logic          full, empty;
  logic [DW-1:0] head;
  logic          xfer, last, pkt_inc, drop_inc;

  // Assert asynchronously, release two edges later.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) rst_sync <= '0;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sys_clk_i),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (smp_data_i),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign last = (beat_q == len_q - 32'd1);

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    len_d         = len_q;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;
    xfer          = 1'b0;
    pkt_inc       = 1'b0;
    drop_inc      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_STREAM;
          beat_d  = '0;
          len_d   = eff_len(pkt_len_i);
        end
      end
      ST_STREAM: begin
        m_axis_tvalid = !empty;
        m_axis_tdata  = empty ? '0 : head;
        m_axis_tlast  = !empty && last;
        xfer          = !empty && m_axis_tready;
        pop           = xfer;
        if (xfer) begin
          if (last) begin
            beat_d  = '0;
            len_d   = eff_len(pkt_len_i);
            pkt_inc = 1'b1;
          end else begin
            beat_d = beat_q + 32'd1;
          end
        end
        // Decide on the post-transfer count so a tlast beat taken in the same
        // cycle as the disable does not trigger a whole padding packet.
        if (!enable_i) begin
          if (beat_d != '0) state_d = ST_FLUSH;
          else if (empty)   state_d = ST_IDLE;
        end
        if (smp_valid_i && state_d == ST_STREAM) begin
          if (full && !pop) drop_inc = 1'b1;
          else              push     = 1'b1;
        end
      end
      ST_FLUSH: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = empty ? '0 : head;
        m_axis_tlast  = last;
        xfer          = m_axis_tready;
        pop           = xfer && !empty;
        if (xfer) begin
          if (last) begin
            beat_d  = '0;
            len_d   = eff_len(pkt_len_i);
            pkt_inc = 1'b1;
            flush   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 32'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      len_q   <= 32'd1;
      drop_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      if (pkt_inc)                 pkt_q  <= pkt_q + 32'd1;
      if (drop_inc && drop_q != '1) drop_q <= drop_q + 32'd1;
    end
  end

  assign m_axis_tkeep = KEEP_ALL[DW/8-1:0];
  assign drop_cnt_o   = drop_q;
  assign pkt_cnt_o    = pkt_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_packetizer.sv
// Bench for axis_packetizer: directed scenarios plus a randomized run, all
// checked against a queue-based transaction model of the packetizer rules.
module tb_axis_packetizer;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic            enable;
  logic [31:0]     pkt_len;
  logic            smp_valid;
  logic [DW-1:0]   smp_data;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic            tvalid;
  logic            tlast;
  logic [DW/8-1:0] tkeep;
  logic [31:0]     drop_cnt;
  logic [31:0]     pkt_cnt;
  logic            busy;

  always #5 clk = ~clk;

  axis_packetizer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .sys_clk_i     (clk),
    .sys_rstn_i    (rstn),
    .enable_i      (enable),
    .pkt_len_i     (pkt_len),
    .smp_valid_i   (smp_valid),
    .smp_data_i    (smp_data),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .m_axis_tkeep  (tkeep),
    .drop_cnt_o    (drop_cnt),
    .pkt_cnt_o     (pkt_cnt),
    .busy_o        (busy)
  );

  int checks = 0;
  int passes = 0;

  typedef enum {M_IDLE, M_STREAM, M_FLUSH} mmode_t;
  mmode_t        m_mode;
  logic [DW-1:0] m_buf[$];
  int unsigned   m_len;
  int unsigned   m_beat;
  logic [31:0]   m_pkt;
  logic [31:0]   m_drop;

  int            mis_valid, mis_data, mis_last, mis_busy, hold_viol;
  logic [DW-1:0] obs_d[$];
  bit            obs_l[$];
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_buf.delete();
    m_len  = 1;
    m_beat = 0;
    m_pkt  = '0;
    m_drop = '0;
    prev_stall = 1'b0;
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_l.delete(); exp_d.delete(); exp_l.delete();
    mis_valid = 0; mis_data = 0; mis_last = 0; mis_busy = 0; hold_viol = 0;
  endtask

  // Packet bookkeeping after one beat has been accepted downstream.
  task automatic model_beat_done(output bit was_last);
    was_last = (m_beat == m_len - 1);
    if (was_last) begin
      m_beat = 0;
      m_pkt  = m_pkt + 1;
      m_len  = (pkt_len == 0) ? 1 : pkt_len;
    end else begin
      m_beat++;
    end
  endtask

  // One clock: observe DUT before the edge, advance the model with the same inputs.
  task automatic cycle();
    bit            mv, ml, mx, was_empty, was_full, wl;
    logic [DW-1:0] md;
    @(negedge clk);
    mv = (m_mode == M_STREAM) ? (m_buf.size() > 0) : (m_mode == M_FLUSH);
    md = (mv && m_buf.size() > 0) ? m_buf[0] : '0;
    ml = mv && (m_beat == m_len - 1);
    if (tvalid !== mv) mis_valid++;
    if (tdata !== md)  mis_data++;
    if (tlast !== ml)  mis_last++;
    if (busy !== (m_mode != M_IDLE)) mis_busy++;
    if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) hold_viol++;
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
    if (tvalid && tready) begin
      obs_d.push_back(tdata);
      obs_l.push_back(tlast);
    end
    mx = mv && tready;
    if (mx) begin
      exp_d.push_back(md);
      exp_l.push_back(ml);
    end
    case (m_mode)
      M_IDLE: if (enable) begin
        m_mode = M_STREAM;
        m_len  = (pkt_len == 0) ? 1 : pkt_len;
        m_beat = 0;
      end
      M_STREAM: begin
        was_empty = (m_buf.size() == 0);
        was_full  = (m_buf.size() == DEPTH);
        if (mx) begin
          void'(m_buf.pop_front());
          model_beat_done(wl);
        end
        if (!enable) begin
          if (m_beat != 0)    m_mode = M_FLUSH;
          else if (was_empty) m_mode = M_IDLE;
        end
        if (smp_valid && m_mode == M_STREAM) begin
          if (was_full && !mx) begin
            if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
          end else begin
            m_buf.push_back(smp_data);
          end
        end
      end
      M_FLUSH: if (mx) begin
        if (m_buf.size() > 0) void'(m_buf.pop_front());
        model_beat_done(wl);
        if (wl) begin
          m_mode = M_IDLE;
          m_buf.delete();
        end
      end
      default: m_mode = M_IDLE;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (m_mode == M_IDLE && !busy) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0; enable = 1'b0; smp_valid = 1'b0; smp_data = '0;
    tready = 1'b0; pkt_len = 32'd4;
    model_reset();
    repeat (3) cycle();
    rstn = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    logic [DW/8-1:0] keep_ones;
    keep_ones = '1;
    clear_obs();
    apply_reset();
    checks++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", tvalid); else passes++;
    checks++; if (tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", tlast); else passes++;
    checks++; if (tdata !== '0) $display("FAIL reset_tdata got %h want 0", tdata); else passes++;
    checks++; if (tkeep !== keep_ones) $display("FAIL tkeep got %h want %h", tkeep, keep_ones); else passes++;
    checks++; if (pkt_cnt !== 32'd0) $display("FAIL reset_pkt_cnt got %0d want 0", pkt_cnt); else passes++;
    checks++; if (drop_cnt !== 32'd0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_basic();
    bit ok;
    clear_obs();
    tready = 1'b1; pkt_len = 32'd4; enable = 1'b1;
    cycle();
    for (int i = 1; i <= 8; i++) begin
      smp_valid = 1'b1; smp_data = DW'(i);
      cycle();
    end
    smp_valid = 1'b0; enable = 1'b0;
    drain(30, ok);
    checks++; if (!ok) $display("FAIL basic_idle_timeout got busy=%b want idle", busy); else passes++;
    checks++; if (obs_d.size() != 8) $display("FAIL basic_beats got %0d want 8", obs_d.size()); else passes++;
    for (int i = 0; i < obs_d.size() && i < 8; i++) begin
      checks++;
      if (obs_d[i] !== DW'(i + 1) || obs_l[i] !== (i % 4 == 3))
        $display("FAIL basic_beat%0d got data=%0d last=%b want data=%0d last=%b",
                 i, obs_d[i], obs_l[i], i + 1, (i % 4 == 3));
      else passes++;
    end
    checks++; if (pkt_cnt !== 32'd2) $display("FAIL basic_pkt_cnt got %0d want 2", pkt_cnt); else passes++;
    checks++; if (mis_valid + mis_data + mis_last + mis_busy != 0)
      $display("FAIL basic_model got v=%0d d=%0d l=%0d b=%0d mismatches want 0", mis_valid, mis_data, mis_last, mis_busy);
    else passes++;
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs();
    tready = 1'b0; pkt_len = 32'd4; enable = 1'b1;
    cycle();
    for (int i = 1; i <= 12; i++) begin
      smp_valid = 1'b1; smp_data = DW'(i); tready = ~tready;
      cycle();
    end
    smp_valid = 1'b0;
    for (int i = 0; i < 80 && obs_d.size() < 12; i++) begin
      tready = ~tready;
      cycle();
    end
    enable = 1'b0; tready = 1'b1;
    drain(30, ok);
    checks++; if (!ok) $display("FAIL bp_idle_timeout got busy=%b want idle", busy); else passes++;
    checks++; if (obs_d.size() != 12) $display("FAIL bp_beats got %0d want 12", obs_d.size()); else passes++;
    for (int i = 0; i < obs_d.size() && i < 12; i++) begin
      checks++;
      if (obs_d[i] !== DW'(i + 1) || obs_l[i] !== (i % 4 == 3))
        $display("FAIL bp_beat%0d got data=%0d last=%b want data=%0d last=%b",
                 i, obs_d[i], obs_l[i], i + 1, (i % 4 == 3));
      else passes++;
    end
    checks++; if (hold_viol != 0) $display("FAIL bp_hold got %0d violations want 0", hold_viol); else passes++;
    checks++; if (drop_cnt !== 32'd0) $display("FAIL bp_drop got %0d want 0", drop_cnt); else passes++;
    checks++; if (pkt_cnt !== 32'd5) $display("FAIL bp_pkt_cnt got %0d want 5", pkt_cnt); else passes++;
  endtask

  task automatic test_overflow();
    bit ok;
    clear_obs();
    tready = 1'b0; pkt_len = 32'd16; enable = 1'b1;
    cycle();
    for (int i = 1; i <= 20; i++) begin
      smp_valid = 1'b1; smp_data = DW'(100 + i);
      cycle();
    end
    smp_valid = 1'b0;
    checks++; if (drop_cnt !== 32'd4) $display("FAIL ovf_drop got %0d want 4", drop_cnt); else passes++;
    checks++; if (tvalid !== 1'b1 || tdata !== DW'(101))
      $display("FAIL ovf_head got valid=%b data=%0d want valid=1 data=101", tvalid, tdata);
    else passes++;
    tready = 1'b1;
    for (int i = 0; i < 40 && obs_d.size() < 16; i++) cycle();
    enable = 1'b0;
    drain(30, ok);
    checks++; if (!ok) $display("FAIL ovf_idle_timeout got busy=%b want idle", busy); else passes++;
    checks++; if (obs_d.size() != 16) $display("FAIL ovf_beats got %0d want 16", obs_d.size()); else passes++;
    for (int i = 0; i < obs_d.size() && i < 16; i++) begin
      checks++;
      if (obs_d[i] !== DW'(101 + i) || obs_l[i] !== (i == 15))
        $display("FAIL ovf_beat%0d got data=%0d last=%b want data=%0d last=%b",
                 i, obs_d[i], obs_l[i], 101 + i, (i == 15));
      else passes++;
    end
  endtask

  task automatic test_flush();
    bit ok;
    logic [31:0] pkt_before;
    clear_obs();
    pkt_before = m_pkt;
    tready = 1'b1; pkt_len = 32'd8; enable = 1'b1;
    cycle();
    for (int i = 1; i <= 4; i++) begin
      smp_valid = 1'b1; smp_data = DW'(i);
      cycle();
    end
    smp_valid = 1'b0; enable = 1'b0;
    drain(30, ok);
    cycle();
    checks++; if (!ok) $display("FAIL flush_idle_timeout got busy=%b want idle", busy); else passes++;
    checks++; if (obs_d.size() != 8) $display("FAIL flush_beats got %0d want 8", obs_d.size()); else passes++;
    for (int i = 0; i < obs_d.size() && i < 8; i++) begin
      checks++;
      if (obs_d[i] !== ((i < 4) ? DW'(i + 1) : '0) || obs_l[i] !== (i == 7))
        $display("FAIL flush_beat%0d got data=%0d last=%b want data=%0d last=%b",
                 i, obs_d[i], obs_l[i], (i < 4) ? i + 1 : 0, (i == 7));
      else passes++;
    end
    checks++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else passes++;
    checks++; if (pkt_cnt !== pkt_before + 1) $display("FAIL flush_pkt_cnt got %0d want %0d", pkt_cnt, pkt_before + 1); else passes++;
  endtask

  task automatic test_zero_len();
    bit ok;
    logic [31:0] pkt_before;
    clear_obs();
    pkt_before = m_pkt;
    tready = 1'b1; pkt_len = 32'd0; enable = 1'b1;
    cycle();
    for (int i = 1; i <= 6; i++) begin
      smp_valid = 1'b1; smp_data = DW'(50 + i);
      cycle();
    end
    smp_valid = 1'b0; enable = 1'b0;
    drain(30, ok);
    checks++; if (!ok) $display("FAIL zlen_idle_timeout got busy=%b want idle", busy); else passes++;
    checks++; if (obs_d.size() != 6) $display("FAIL zlen_beats got %0d want 6", obs_d.size()); else passes++;
    for (int i = 0; i < obs_d.size() && i < 6; i++) begin
      checks++;
      if (obs_d[i] !== DW'(51 + i) || obs_l[i] !== 1'b1)
        $display("FAIL zlen_beat%0d got data=%0d last=%b want data=%0d last=1", i, obs_d[i], obs_l[i], 51 + i);
      else passes++;
    end
    checks++; if (pkt_cnt !== pkt_before + 6) $display("FAIL zlen_pkt_cnt got %0d want %0d", pkt_cnt, pkt_before + 6); else passes++;
  endtask

  task automatic test_random();
    bit ok;
    int bad;
    clear_obs();
    enable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      pkt_len   = $urandom_range(0, 6);
      smp_valid = ($urandom_range(0, 9) < 6);
      smp_data  = {$urandom, $urandom};
      tready    = $urandom_range(0, 1);
      cycle();
    end
    enable = 1'b0; smp_valid = 1'b0; tready = 1'b1;
    drain(200, ok);
    checks++; if (!ok) $display("FAIL rand_idle_timeout got busy=%b want idle", busy); else passes++;
    checks++; if (mis_valid != 0) $display("FAIL rand_tvalid got %0d mismatches want 0", mis_valid); else passes++;
    checks++; if (mis_data != 0) $display("FAIL rand_tdata got %0d mismatches want 0", mis_data); else passes++;
    checks++; if (mis_last != 0) $display("FAIL rand_tlast got %0d mismatches want 0", mis_last); else passes++;
    checks++; if (mis_busy != 0) $display("FAIL rand_busy got %0d mismatches want 0", mis_busy); else passes++;
    checks++; if (hold_viol != 0) $display("FAIL rand_hold got %0d violations want 0", hold_viol); else passes++;
    bad = (obs_d.size() != exp_d.size()) ? 1 : 0;
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++)
      if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) bad++;
    checks++; if (bad != 0) $display("FAIL rand_stream got %0d bad beats of %0d want 0 of %0d", bad, obs_d.size(), exp_d.size()); else passes++;
    checks++; if (pkt_cnt !== m_pkt) $display("FAIL rand_pkt_cnt got %0d want %0d", pkt_cnt, m_pkt); else passes++;
    checks++; if (drop_cnt !== m_drop) $display("FAIL rand_drop_cnt got %0d want %0d", drop_cnt, m_drop); else passes++;
  endtask

  task automatic test_reset_midpacket();
    bit ok;
    clear_obs();
    tready = 1'b0; pkt_len = 32'd8; enable = 1'b1;
    cycle();
    for (int i = 1; i <= 3; i++) begin
      smp_valid = 1'b1; smp_data = DW'(70 + i);
      cycle();
    end
    smp_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++; if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== '0)
      $display("FAIL midrst_stream got valid=%b last=%b data=%0d want 0 0 0", tvalid, tlast, tdata);
    else passes++;
    checks++; if (busy !== 1'b0 || pkt_cnt !== 32'd0 || drop_cnt !== 32'd0)
      $display("FAIL midrst_status got busy=%b pkt=%0d drop=%0d want 0 0 0", busy, pkt_cnt, drop_cnt);
    else passes++;
    enable = 1'b0;
    model_reset();
    clear_obs();
    repeat (2) cycle();
    rstn = 1'b1;
    repeat (3) cycle();
    tready = 1'b1; pkt_len = 32'd2; enable = 1'b1;
    cycle();
    for (int i = 1; i <= 2; i++) begin
      smp_valid = 1'b1; smp_data = DW'(90 + i);
      cycle();
    end
    smp_valid = 1'b0; enable = 1'b0;
    drain(30, ok);
    checks++; if (!ok) $display("FAIL midrst_idle_timeout got busy=%b want idle", busy); else passes++;
    checks++; if (obs_d.size() != 2) $display("FAIL midrst_beats got %0d want 2", obs_d.size()); else passes++;
    for (int i = 0; i < obs_d.size() && i < 2; i++) begin
      checks++;
      if (obs_d[i] !== DW'(91 + i) || obs_l[i] !== (i == 1))
        $display("FAIL midrst_beat%0d got data=%0d last=%b want data=%0d last=%b",
                 i, obs_d[i], obs_l[i], 91 + i, (i == 1));
      else passes++;
    end
    checks++; if (pkt_cnt !== 32'd1) $display("FAIL midrst_pkt_cnt got %0d want 1", pkt_cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_flush();
    test_zero_len();
    test_random();
    test_reset_midpacket();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
